crc32_stream: RTL

- Sequential, streaming Ethernet CRC-32 engine. Polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
- Accepts framed data beats of parametrised width with a byte-valid mask, accumulates the CRC across beats, and presents a per-frame result through a held valid/ready handshake.
- Sits between MAC RX/TX framing and the FCS insert/strip logic. Used as FCS generator (crc) and checker (residue flag) at the same time.

---
 rtl/crc32_stream.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/crc32_stream.sv
// crc32_stream
// ----------------------------------------------------------------------------
// Streaming Ethernet CRC-32 engine: reflected polynomial 0x04C11DB7, register
// seeded with 0xFFFFFFFF at start of frame, result complemented on output.
// Accumulates the CRC over framed beats and hands one result per frame out
// through a held valid/ready handshake. The same result serves as the FCS to
// insert (res_crc) and as the FCS check (res_ok, residue 0xDEBB20E3).
//
// Ports
//   sys_clk, sys_rst_n   clock, synchronous active-low reset
//   s_valid / s_ready    input beat handshake
//   s_data [DATA_W]      beat data, byte 0 = s_data[7:0] is first on the wire
//   s_keep [DATA_W/8]    byte-valid mask, expected contiguous from bit 0
//   s_sop / s_eop        first / last beat of a frame
//   res_valid/res_ready  result handshake, res_* held while stalled
//   res_crc [32]         complemented CRC, res_crc[7:0] is the first FCS byte
//   res_ok               frame including its FCS leaves the good residue
//   res_len [LEN_W]      accepted byte count, saturating at all-ones
//   res_err              framing violation seen in this frame
// ----------------------------------------------------------------------------
module crc32_stream #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_sop,
    input  logic                s_eop,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_crc,
    output logic                res_ok,
    output logic [LEN_W-1:0]    res_len,
    output logic                res_err
);

    localparam int          NB        = DATA_W / 8;
    localparam int          CNT_W     = $clog2(NB + 1);
    localparam logic [31:0] POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE   = 32'hDEBB_20E3;

    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("crc32_stream: DATA_W must be 8, 16, 32 or 64");
    end
    if (LEN_W < CNT_W) begin : g_bad_len_w
        $error("crc32_stream: LEN_W too narrow for one beat's byte count");
    end

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // One byte through the reflected LFSR, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_crc_q, res_crc_d;
    logic               res_ok_q, res_ok_d;
    logic [LEN_W-1:0]   res_len_q, res_len_d;
    logic               res_err_q, res_err_d;

    logic               accept;
    logic               beat_take;
    logic               frame_done;
    logic [NB-1:0]      keep_eff;
    logic [CNT_W-1:0]   keep_cnt;
    logic               beat_err;
    logic [31:0]        crc_beat;
    logic [LEN_W-1:0]   len_base;
    logic [LEN_W:0]     len_sum;
    logic [LEN_W-1:0]   len_beat;
    logic               err_beat;

    // A pending, unconsumed result stalls every input beat, framed or not.
    assign s_ready = ~(res_valid_q & ~res_ready);
    assign accept  = s_valid & s_ready;

    // Keep mask decode: only the run of ones starting at bit 0 counts as data.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin : keep_decode
        logic run;
        run      = 1'b1;
        keep_eff = '0;
        keep_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            if (run && s_keep[i]) begin
                keep_eff[i] = 1'b1;
                keep_cnt    = keep_cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        beat_err = (s_keep == '0) || (s_keep != keep_eff) || (!s_eop && !(&s_keep));
    end

    // Beat contribution, chained byte 0 first. A start-of-frame beat seeds
    // from the init value, which also discards an aborted frame.
    always_comb begin : beat_math
        crc_beat = s_sop ? CRC_INIT : crc_q;
        for (int i = 0; i < NB; i++) begin
            if (keep_eff[i]) begin
                crc_beat = crc_byte(crc_beat, s_data[8*i +: 8]);
            end
        end
        len_base = s_sop ? '0 : len_q;
        len_sum  = {1'b0, len_base} + {{(LEN_W + 1 - CNT_W){1'b0}}, keep_cnt};
        len_beat = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
        err_beat = (s_sop ? 1'b0 : err_q) | beat_err;
    end

    // FSM: state register.
    // NOTE: reset is synchronous, sampled inside the clocked block, and all
    // sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Outside a frame only a start-of-frame beat matters.
    always_comb begin
        state_d = state_q;
        if (accept && (s_sop || state_q == ST_ACTIVE)) begin
            state_d = s_eop ? ST_IDLE : ST_ACTIVE;
        end
    end

    // FSM: outputs. Beats seen in IDLE without s_sop are accepted and dropped.
    always_comb begin
        beat_take  = accept && (s_sop || state_q == ST_ACTIVE);
        frame_done = beat_take && s_eop;
    end

    // Accumulator and result holding registers.
    always_comb begin
        crc_d       = crc_q;
        len_d       = len_q;
        err_d       = err_q;
        res_valid_d = res_valid_q & ~res_ready;
        res_crc_d   = res_crc_q;
        res_ok_d    = res_ok_q;
        res_len_d   = res_len_q;
        res_err_d   = res_err_q;
        if (beat_take) begin
            crc_d = crc_beat;
            len_d = len_beat;
            err_d = err_beat;
        end
        // Only reachable when the slot is free or being consumed this cycle.
        if (frame_done) begin
            res_valid_d = 1'b1;
            res_crc_d   = ~crc_beat;
            res_ok_d    = (crc_beat == RESIDUE);
            res_len_d   = len_beat;
            res_err_d   = err_beat;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            crc_q       <= CRC_INIT;
            len_q       <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_crc_q   <= '0;
            res_ok_q    <= 1'b0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            len_q       <= len_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_ok_q    <= res_ok_d;
            res_len_q   <= res_len_d;
            res_err_q   <= res_err_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign res_ok    = res_ok_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;

endmodule
